// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded instruction from ID, writeback bypass, stall/flush
// controls, and the registered EX-side copy plus the hazard stall request.
interface id_ex_stage_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3,
    parameter int unsigned FW = 5
);
    logic          id_valid;
    logic [AW-1:0] id_SA;
    logic [AW-1:0] id_SB;
    logic [AW-1:0] id_DA;
    logic [DW-1:0] id_A_data;
    logic [DW-1:0] id_B_data;
    logic [DW-1:0] id_constant;
    logic          id_MA;
    logic          id_MB;
    logic [FW-1:0] id_FS;
    logic          id_RW;
    logic          id_MW;
    logic          id_MD;

    logic          wb_RW;
    logic [AW-1:0] wb_DA;
    logic [DW-1:0] wb_data;

    logic          stall_in;
    logic          flush;

    logic          ex_valid;
    logic [AW-1:0] ex_SA;
    logic [AW-1:0] ex_SB;
    logic [AW-1:0] ex_DA;
    logic [DW-1:0] ex_A_data;
    logic [DW-1:0] ex_B_data;
    logic [DW-1:0] ex_constant;
    logic          ex_MA;
    logic          ex_MB;
    logic [FW-1:0] ex_FS;
    logic          ex_RW;
    logic          ex_MW;
    logic          ex_MD;

    logic          hazard_stall;

    modport master (
        output id_valid, id_SA, id_SB, id_DA, id_A_data, id_B_data, id_constant,
               id_MA, id_MB, id_FS, id_RW, id_MW, id_MD,
               wb_RW, wb_DA, wb_data, stall_in, flush,
        input  ex_valid, ex_SA, ex_SB, ex_DA, ex_A_data, ex_B_data, ex_constant,
               ex_MA, ex_MB, ex_FS, ex_RW, ex_MW, ex_MD, hazard_stall
    );

    modport slave (
        input  id_valid, id_SA, id_SB, id_DA, id_A_data, id_B_data, id_constant,
               id_MA, id_MB, id_FS, id_RW, id_MW, id_MD,
               wb_RW, wb_DA, wb_data, stall_in, flush,
        output ex_valid, ex_SA, ex_SB, ex_DA, ex_A_data, ex_B_data, ex_constant,
               ex_MA, ex_MB, ex_FS, ex_RW, ex_MW, ex_MD, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, RAW hazard bubbling against the
// instruction in EX, and external stall/flush.
module id_ex_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3,
    parameter int unsigned FW = 5
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] sa;
        logic [AW-1:0] sb;
        logic [AW-1:0] da;
        logic [DW-1:0] a_data;
        logic [DW-1:0] b_data;
        logic [DW-1:0] constant;
        logic          ma;
        logic          mb;
        logic [FW-1:0] fs;
        logic          rw;
        logic          mw;
        logic          md;
    } ex_t;

    ex_t  r_ex;
    ex_t  w_id;
    logic w_hazard;
    logic w_bubble;
    logic w_load;

    // RAW against EX producer; operands taken from the constant / non-RF path never conflict
    assign w_hazard = bus.id_valid & r_ex.valid & r_ex.rw &
                      (((r_ex.da == bus.id_SA) & ~bus.id_MA) |
                       ((r_ex.da == bus.id_SB) & ~bus.id_MB));

    assign bus.hazard_stall = w_hazard & ~bus.flush;

    assign w_bubble = bus.flush | (~bus.stall_in & w_hazard);
    assign w_load   = ~bus.flush & ~bus.stall_in & ~w_hazard;

    // Next EX contents from ID, with same-cycle writeback forwarded into both operands
    always_comb begin
        w_id          = '0;
        w_id.valid    = bus.id_valid;
        w_id.sa       = bus.id_SA;
        w_id.sb       = bus.id_SB;
        w_id.da       = bus.id_DA;
        w_id.a_data   = (bus.wb_RW && (bus.wb_DA == bus.id_SA)) ? bus.wb_data : bus.id_A_data;
        w_id.b_data   = (bus.wb_RW && (bus.wb_DA == bus.id_SB)) ? bus.wb_data : bus.id_B_data;
        w_id.constant = bus.id_constant;
        w_id.ma       = bus.id_MA;
        w_id.mb       = bus.id_MB;
        w_id.fs       = bus.id_FS;
        w_id.rw       = bus.id_RW & bus.id_valid;
        w_id.mw       = bus.id_MW & bus.id_valid;
        w_id.md       = bus.id_MD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex <= '0;
        end else if (w_bubble) begin
            r_ex <= '0;
        end else if (w_load) begin
            r_ex <= w_id;
        end
    end

    assign bus.ex_valid    = r_ex.valid;
    assign bus.ex_SA       = r_ex.sa;
    assign bus.ex_SB       = r_ex.sb;
    assign bus.ex_DA       = r_ex.da;
    assign bus.ex_A_data   = r_ex.a_data;
    assign bus.ex_B_data   = r_ex.b_data;
    assign bus.ex_constant = r_ex.constant;
    assign bus.ex_MA       = r_ex.ma;
    assign bus.ex_MB       = r_ex.mb;
    assign bus.ex_FS       = r_ex.fs;
    assign bus.ex_RW       = r_ex.rw;
    assign bus.ex_MW       = r_ex.mw;
    assign bus.ex_MD       = r_ex.md;

endmodule
